// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow and a choice of registered or first-word-fall-through read.
module sync_fifo_cfg #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH   = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_C    = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] ONE_C   = (ASIZE+1)'(1);

  // Threshold sanity: reject levels that could never (or always) fire.
  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_cfg: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_cfg: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end
  endgenerate

  // Per-edge request decision; flush wins over both requests.
  typedef struct packed {
    logic wr_ok;
    logic rd_ok;
    logic wr_rej;
    logic rd_rej;
  } acc_t;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   cnt_nxt;
  acc_t             acc;

  // Accept/reject on the flags as they stand before the edge.
  always_comb begin
    acc        = '0;
    acc.wr_ok  = winc & ~wfull  & ~clr;
    acc.rd_ok  = rinc & ~rempty & ~clr;
    acc.wr_rej = winc &  wfull  & ~clr;
    acc.rd_rej = rinc &  rempty & ~clr;
  end

  // Next occupancy; simultaneous accepted read and write cancel out.
  always_comb begin
    cnt_nxt = count;
    if (clr)
      cnt_nxt = '0;
    else if (acc.wr_ok && !acc.rd_ok)
      cnt_nxt = count + ONE_C;
    else if (acc.rd_ok && !acc.wr_ok)
      cnt_nxt = count - ONE_C;
  end

  // Pointers, occupancy, flags (from next count) and sticky error bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      count         <= cnt_nxt;
      wfull         <= (cnt_nxt == DEPTH_C);
      rempty        <= (cnt_nxt == '0);
      walmost_full  <= (cnt_nxt >= AF_C);
      ralmost_empty <= (cnt_nxt <= AE_C);
      if (clr) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (acc.wr_ok)  wptr      <= wptr + ASIZE'(1);
        if (acc.rd_ok)  rptr      <= rptr + ASIZE'(1);
        if (acc.wr_rej) overflow  <= 1'b1;
        if (acc.rd_rej) underflow <= 1'b1;
      end
    end
  end

  // Storage array; deliberately never reset or flushed.
  always_ff @(posedge clk) begin
    if (acc.wr_ok) mem[wptr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; valid whenever anything is stored.
      assign rdata  = mem[rptr];
      assign rvalid = ~rempty;
    end else begin : g_std
      // Registered read: data lands one cycle after the accepted pop and holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= acc.rd_ok;
          if (acc.rd_ok) rdata <= mem[rptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Scoreboard bench: one standard-read and one FWFT instance share stimulus;
// a queue model tracks contents and sticky bits, a negedge monitor compares.
module tb_sync_fifo_cfg;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       winc = 1'b0, rinc = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] rdata0, rdata1;
  logic       rvalid0, rvalid1, wfull0, wfull1, rempty0, rempty1;
  logic       af0, af1, ae0, ae1, ov0, ov1, un0, un1;
  logic [4:0] count0, count1;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // model: FIFO contents, expected standard-read outputs, sticky bits
  byte unsigned mq[$];
  byte unsigned rq[$];
  bit m_ov = 0, m_un = 0;

  sync_fifo_cfg #(.DSIZE(8), .ASIZE(4), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata0), .rvalid(rvalid0), .wfull(wfull0), .rempty(rempty0),
    .walmost_full(af0), .ralmost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(un0));

  sync_fifo_cfg #(.DSIZE(8), .ASIZE(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wdata(wdata), .winc(winc), .rinc(rinc),
    .rdata(rdata1), .rvalid(rvalid1), .wfull(wfull1), .rempty(rempty1),
    .walmost_full(af1), .ralmost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(un1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares both instances against the model each cycle.
  always @(negedge clk) begin
    if (started) begin
      int n;
      n = mq.size();
      chk("count_std",  {27'd0, count0}, n);
      chk("count_fwft", {27'd0, count1}, n);
      chk("rempty_std",  rempty0, n == 0);
      chk("rempty_fwft", rempty1, n == 0);
      chk("wfull_std",   wfull0, n == 16);
      chk("wfull_fwft",  wfull1, n == 16);
      chk("afull_std",   af0, n >= 14);
      chk("afull_fwft",  af1, n >= 14);
      chk("aempty_std",  ae0, n <= 2);
      chk("aempty_fwft", ae1, n <= 2);
      chk("ovf_std",  ov0, m_ov);
      chk("ovf_fwft", ov1, m_ov);
      chk("unf_std",  un0, m_un);
      chk("unf_fwft", un1, m_un);
      chk("rvalid_std", rvalid0, rq.size() != 0);
      if (rq.size() != 0) begin
        byte unsigned e;
        e = rq.pop_front();
        if (rvalid0) chk("rdata_std", rdata0, e);
        rq.delete();
      end
      chk("rvalid_fwft", rvalid1, n != 0);
      if (rvalid1 && n != 0) chk("rdata_fwft", rdata1, mq[0]);
    end
  end

  // One clock: drive inputs, commit model at the edge, settle past it.
  task automatic cyc(input bit w, input bit r, input bit c, input byte unsigned d);
    bit wok, rok;
    winc = w; rinc = r; clr = c; wdata = d;
    @(posedge clk);
    if (c) begin
      mq.delete(); rq.delete(); m_ov = 0; m_un = 0;
    end else begin
      wok = w && mq.size() < 16;
      rok = r && mq.size() > 0;
      if (rok) rq.push_back(mq.pop_front());
      if (wok) mq.push_back(d);
      if (w && !wok) m_ov = 1;
      if (r && !rok) m_un = 1;
    end
    #1;
    winc = 0; rinc = 0; clr = 0;
  endtask

  // Asynchronous reset applied between edges, released after the next edge.
  task automatic do_reset();
    winc = 0; rinc = 0; clr = 0;
    rst = 1'b1;
    mq.delete(); rq.delete(); m_ov = 0; m_un = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    started = 1;
    @(posedge clk); #1;
    rst = 1'b0;

    // ordered write then read-out
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(i));
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    // fill, overflow attempt, full with both, then drain
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    cyc(1, 0, 0, 8'hAA);
    cyc(1, 1, 0, 8'hBB);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    // empty with both: write wins, underflow set
    cyc(1, 1, 0, 8'h5A);
    cyc(0, 0, 0, 8'h00);

    // grow to 9 then flush with a concurrent write
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'(8'h70 + i));
    cyc(1, 0, 1, 8'hEE);
    cyc(0, 0, 0, 8'h00);

    // wrap: preload then 40 interleaved write/read cycles
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) cyc(i % 2 == 0, i % 2 == 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) cyc(1, 1, 0, 8'($urandom));

    // random traffic in phases biased toward full, empty and balanced
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 80; i++)
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            $urandom_range(0, 99) < 2, 8'($urandom));
    end

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'($urandom));
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 8'($urandom));

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
